// File: rtl/bitbrick_pkg.sv
// Shared definitions for the bitbrick datapath and its serial MAC sequencer.
//  - brick sign-mode encodings (sel)
//  - operand precision encodings (prec)
//  - sequencer FSM state type
//  - helpers mapping prec to chunk count and operand masking
package bitbrick_pkg;

    localparam logic [1:0] BB_SEL_SIGNED   = 2'b00;  // a signed,   b signed
    localparam logic [1:0] BB_SEL_UNSIGNED = 2'b01;  // a unsigned, b unsigned
    localparam logic [1:0] BB_SEL_SU       = 2'b10;  // a signed,   b unsigned

    localparam logic [1:0] PREC_2 = 2'b00;
    localparam logic [1:0] PREC_4 = 2'b01;
    localparam logic [1:0] PREC_8 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Index of the last 2-bit chunk (N-1). Reserved prec=11 runs as 8-bit.
    function automatic logic [1:0] last_chunk(input logic [1:0] prec);
        case (prec)
            PREC_2:  return 2'd0;
            PREC_4:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Clear operand bits above the selected precision.
    function automatic logic [7:0] mask_operand(input logic [7:0] v, input logic [1:0] prec);
        case (prec)
            PREC_2:  return v & 8'h03;
            PREC_4:  return v & 8'h0F;
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/bitbrick.sv
// 2x2 bitbrick: multiplies two 2-bit values under one of three sign modes.
//  a, b  in  2  operands
//  sel   in  2  BB_SEL_SIGNED / BB_SEL_UNSIGNED / BB_SEL_SU (a signed, b unsigned)
//  p     out 4  product, two's complement unless sel is unsigned
// Every product of the legal modes fits in 4 bits, so computing at 4-bit
// signed width and keeping the low nibble is exact.
module bitbrick
    import bitbrick_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] p
);

    logic a_sgn, b_sgn;
    logic signed [3:0] a_x, b_x;

    assign a_sgn = (sel == BB_SEL_SIGNED) || (sel == BB_SEL_SU);
    assign b_sgn = (sel == BB_SEL_SIGNED);

    assign a_x = {{2{a_sgn & a[1]}}, a};
    assign b_x = {{2{b_sgn & b[1]}}, b};
    assign p   = a_x * b_x;

endmodule

// File: rtl/bitbrick_serial_mac_ctrl.sv
// Serial MAC sequencer: reuses one 2x2 bitbrick to compute a 2/4/8-bit
// multiply, one chunk pair per cycle (N*N cycles, N = prec/2), and
// shift-accumulates the partial products.
//  clk, rst             clock / async active-high reset
//  in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//  a_in, b_in, prec     operands (LSB-aligned) and precision
//  a_signed, b_signed   operand signedness
//  out_valid, out_ready product handshake
//  p_out                product, exact in ACC_W bits
//  busy                 high while a transaction is in RUN or DONE
module bitbrick_serial_mac_ctrl
    import bitbrick_pkg::*;
#(
    parameter int MAX_BITS = 8,
    parameter int ACC_W    = 2 * MAX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_BITS-1:0] a_in,
    input  logic [MAX_BITS-1:0] b_in,
    input  logic [1:0]          prec,
    input  logic                a_signed,
    input  logic                b_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    p_out,
    output logic                busy
);

    state_t              state;
    logic [MAX_BITS-1:0] a_q, b_q;
    logic                a_sgn_q, b_sgn_q;
    logic [1:0]          last_q;
    logic [1:0]          i_q, j_q;
    logic [ACC_W-1:0]    acc;

    logic [1:0]       a_chunk, b_chunk;
    logic             sa, sb;
    logic [1:0]       sel;
    logic [1:0]       br_a, br_b;
    logic [3:0]       br_p;
    logic [ACC_W-1:0] pp_ext, pp_sh;
    logic [3:0]       shamt;

    assign a_chunk = a_q[{i_q, 1'b0} +: 2];
    assign b_chunk = b_q[{j_q, 1'b0} +: 2];

    // Only the top chunk of a signed operand carries the sign weight.
    assign sa = a_sgn_q && (i_q == last_q);
    assign sb = b_sgn_q && (j_q == last_q);

    // The brick only has a signed*unsigned mode, so the unsigned*signed
    // case swaps operands to put the signed chunk on the a port.
    always_comb begin
        sel  = BB_SEL_UNSIGNED;
        br_a = a_chunk;
        br_b = b_chunk;
        case ({sa, sb})
            2'b11: sel = BB_SEL_SIGNED;
            2'b10: sel = BB_SEL_SU;
            2'b01: begin
                sel  = BB_SEL_SU;
                br_a = b_chunk;
                br_b = a_chunk;
            end
            default: sel = BB_SEL_UNSIGNED;
        endcase
    end

    bitbrick u_brick (
        .a   (br_a),
        .b   (br_b),
        .sel (sel),
        .p   (br_p)
    );

    assign pp_ext = (sel == BB_SEL_UNSIGNED) ? {{(ACC_W-4){1'b0}}, br_p}
                                             : {{(ACC_W-4){br_p[3]}}, br_p};
    assign shamt  = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    assign pp_sh  = pp_ext << shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p_out     <= '0;
            acc       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_sgn_q   <= 1'b0;
            b_sgn_q   <= 1'b0;
            last_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= mask_operand(a_in, prec);
                        b_q      <= mask_operand(b_in, prec);
                        a_sgn_q  <= a_signed;
                        b_sgn_q  <= b_signed;
                        last_q   <= last_chunk(prec);
                        acc      <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc + pp_sh;
                    // j is the inner loop over B chunks, i the outer over A.
                    if (j_q == last_q) begin
                        j_q <= '0;
                        if (i_q == last_q) begin
                            i_q   <= '0;
                            state <= DONE;
                        end else begin
                            i_q <= i_q + 2'd1;
                        end
                    end else begin
                        j_q <= j_q + 2'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the finished accumulator;
                    // out_ready is only honoured once out_valid is up.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        p_out     <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitbrick_serial_mac_ctrl.sv
module tb_bitbrick_serial_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a_in, b_in;
    logic [1:0]  prec;
    logic        a_signed, b_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p_out;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    bitbrick_serial_mac_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .prec      (prec),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_out     (p_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: plain integer product of the operands as interpreted at prec.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] pr, input logic as, input logic bs);
        int bits, av, bv;
        bits = (pr == 2'd0) ? 2 : (pr == 2'd1) ? 4 : 8;
        av = int'(a) & ((1 << bits) - 1);
        bv = int'(b) & ((1 << bits) - 1);
        if (as && av >= (1 << (bits - 1))) av -= (1 << bits);
        if (bs && bv >= (1 << (bits - 1))) bv -= (1 << bits);
        return 16'(av * bv);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_p_out"},     p_out,     0);
    endtask

    // One full transaction. noisy: wiggle inputs (and stray out_ready /
    // in_valid) while the operation runs, all of which must be ignored.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] pr,
                           input logic as, input logic bs, input int hold, input bit noisy);
        logic [15:0] exp;
        int n, lat;
        bit seen;
        exp = model(a, b, pr, as, bs);
        n = (pr == 2'd0) ? 1 : (pr == 2'd1) ? 2 : 4;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1; a_in = a; b_in = b; prec = pr; a_signed = as; b_signed = bs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (noisy) begin
            a_in = 8'($urandom); b_in = 8'($urandom); prec = 2'($urandom);
            a_signed = 1'($urandom); b_signed = 1'($urandom);
        end
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                out_ready = 1'b0;
                in_valid = 1'b0;
            end else begin
                chk("run_busy", busy, 1);
                chk("run_in_ready", in_ready, 0);
                if (noisy) begin
                    out_ready = 1'($urandom);
                    in_valid  = 1'($urandom);
                end
            end
        end
        chk("out_seen", seen, 1);
        chk("latency", lat, n * n + 1);
        chk("p_out", p_out, exp);
        chk("done_busy", busy, 1);
        chk("done_in_ready", in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_p_out", p_out, exp);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int acc_cnt, hs_cnt;
        bit pending;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; prec = '0; a_signed = 1'b0; b_signed = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Directed cases
        run_txn(8'h80, 8'h80, 2'b10, 1, 1, 1, 0);        // 0x4000
        run_txn(8'hFF, 8'hFF, 2'b10, 0, 0, 0, 0);        // 0xFE01
        run_txn(8'h08, 8'h0F, 2'b01, 1, 0, 2, 0);        // 0xFF88
        run_txn(8'd200, 8'hFD, 2'b10, 0, 1, 0, 0);       // 0xFDA8 (swap path)
        run_txn(8'hAE, 8'h02, 2'b00, 1, 1, 5, 0);        // 0x0004, garbage upper a bits
        run_txn(8'h7F, 8'h81, 2'b11, 1, 1, 0, 0);        // reserved prec acts as 8-bit
        run_txn(8'hF3, 8'h5C, 2'b01, 0, 1, 0, 1);        // upper bits ignored at 4-bit

        // Reset mid-RUN of an 8-bit op
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'h5A; b_in = 8'hC3; prec = 2'b10; a_signed = 1; b_signed = 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_discard_valid", out_valid, 0);
        chk("rst_discard_p_out", p_out, 0);
        run_txn(8'h5A, 8'hC3, 2'b10, 1, 1, 0, 0);

        // Reset mid-DONE
        @(negedge clk);
        in_valid = 1'b1; a_in = 8'h03; b_in = 8'h03; prec = 2'b00; a_signed = 0; b_signed = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_done_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_vals("middone_rst");
        @(negedge clk);
        rst = 1'b0;

        // in_valid held high: one accept per completed handshake
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        a_in = 8'h02; b_in = 8'h03; prec = 2'b00; a_signed = 1; b_signed = 0;  // -2*3 = -6
        acc_cnt = 0; hs_cnt = 0; pending = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid && out_ready) begin
                hs_cnt++;
                chk("stream_p_out", p_out, 16'hFFFA);
                pending = 0;
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                chk("stream_one_inflight", pending, 0);
                pending = 1;
            end
            @(negedge clk);
        end
        chk("stream_accepts", acc_cnt, 10);
        chk("stream_handshakes", hs_cnt, 10);
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            run_txn(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
